// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_elastic
// Brief    : Elastic DEPTH-stage pipeline register carrying a control and a
//            data bundle with valid/ready handshakes, enable and flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = 8,
    parameter int DEPTH               = 2,
    parameter int ZERO_CTRL_ON_BUBBLE = 1,
    parameter int COUNT_WIDTH         = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [CTRL_WIDTH-1:0]  i_ctrl,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [CTRL_WIDTH-1:0]  o_ctrl,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [DEPTH-1:0]       r_valid;
    logic [CTRL_WIDTH-1:0]  r_ctrl [DEPTH];
    logic [DATA_WIDTH-1:0]  r_data [DEPTH];
    logic [COUNT_WIDTH-1:0] r_count;

    logic [DEPTH-1:0]       w_rdy;
    logic                   w_acc;
    logic [DEPTH-1:0]       w_src_valid;
    logic [CTRL_WIDTH-1:0]  w_src_ctrl [DEPTH];
    logic [DATA_WIDTH-1:0]  w_src_data [DEPTH];
    logic [DEPTH-1:0]       w_advance;
    logic [DEPTH-1:0]       w_valid_next;
    logic [DEPTH-1:0]       w_load;
    logic [COUNT_WIDTH-1:0] w_count_next;

    // Stage k's source is the stage below it; stage 0 is fed from upstream.
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
        if (k == 0) begin : g_input
            assign w_src_valid[k] = i_valid;
            assign w_src_ctrl[k]  = i_ctrl;
            assign w_src_data[k]  = i_data;
        end else begin : g_chain
            assign w_src_valid[k] = r_valid[k-1];
            assign w_src_ctrl[k]  = r_ctrl[k-1];
            assign w_src_data[k]  = r_data[k-1];
        end
    end

    // Ready ripples from the downstream side; a bubble anywhere above a
    // stage lets that stage move, which gives full throughput.
    always_comb begin
        w_rdy = '0;
        w_acc = i_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_acc    = ~r_valid[k] | w_acc;
            w_rdy[k] = w_acc;
        end
    end

    always_comb begin
        w_advance    = '0;
        w_valid_next = '0;
        w_load       = '0;
        w_count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_advance[k]    = i_enable & ~i_flush & w_rdy[k];
            w_valid_next[k] = i_flush ? 1'b0
                            : (w_advance[k] ? w_src_valid[k] : r_valid[k]);
            w_load[k]       = w_advance[k] & w_src_valid[k];
            w_count_next    = w_count_next + COUNT_WIDTH'(w_valid_next[k]);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_ctrl[k] <= '0;
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            // Payload only moves with a real beat so bubbles keep the last value.
            for (int k = 0; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_ctrl[k] <= w_src_ctrl[k];
                    r_data[k] <= w_src_data[k];
                end
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1] & i_enable;
    assign o_ready = i_reset & ((w_rdy[0] & i_enable) | i_flush);
    assign o_ctrl  = ((ZERO_CTRL_ON_BUBBLE != 0) && !o_valid) ? '0 : r_ctrl[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic inter-stage pipeline register for the MIPS pipeline.
- Carries a control bundle and a data bundle through DEPTH register stages.
- Per-stage valid bits with a valid/ready handshake on both sides, plus global enable and synchronous flush.
- Control signals are forced to zero on bubbles, so squashed slots never raise write strobes.

Parameters:
- DATA_WIDTH, 64: data payload width (e.g. bus_b plus alu_result).
- CTRL_WIDTH, 8: control payload width (e.g. mem_rd_src, mem_wr_src, mem_write, wb, mem_to_reg).
- DEPTH, 2: number of register stages, >= 1.
- ZERO_CTRL_ON_BUBBLE, 1: 1 = o_ctrl forced to 0 when o_valid = 0; 0 = raw stage contents.
- COUNT_WIDTH, $clog2(DEPTH+1): width of the occupancy output.

Ports:
- i_clk, in, 1: clock, rising edge.
- i_reset, in, 1: asynchronous, active-low reset (0 = reset).
- i_enable, in, 1: global advance enable (debug-unit step control).
- i_flush, in, 1: synchronous kill of all in-flight beats.
- i_valid, in, 1: upstream beat valid.
- o_ready, out, 1: block accepts the upstream beat this cycle.
- i_ctrl, in, CTRL_WIDTH: control payload.
- i_data, in, DATA_WIDTH: data payload.
- o_valid, out, 1: output beat valid.
- i_ready, in, 1: downstream accepts the output beat.
- o_ctrl, out, CTRL_WIDTH: control payload of the last stage.
- o_data, out, DATA_WIDTH: data payload of the last stage.
- o_count, out, COUNT_WIDTH: number of valid stages.

Behaviour:
- Stages are k = 0..DEPTH-1; stage 0 faces upstream, stage DEPTH-1 drives the outputs. Each stage holds v[k], ctrl[k] and data[k].
- Reset (i_reset = 0, asynchronous):
  - All v[k], ctrl[k] and data[k] clear to 0 immediately.
  - Outputs while in reset: o_valid = 0, o_ctrl = 0, o_data = 0, o_count = 0, o_ready = 0.
  - The first edge after release behaves as an empty pipe; reset mid-transfer drops all beats.
- Ready chain (combinational):
  - rdy[DEPTH] = i_ready; rdy[k] = !v[k] | rdy[k+1].
  - o_ready = (rdy[0] & i_enable) | i_flush.
  - Every stage can advance in the same cycle: full throughput, no bubble on back-pressure release.
- Output side:
  - o_valid = v[DEPTH-1] & i_enable.
  - A downstream transfer occurs when o_valid & i_ready.
  - A valid head stage is held while i_ready = 0.
- Advance (rising edge, i_enable = 1, i_flush = 0), for each k with rdy[k] = 1:
  - v[k] <= v[k-1], where v[-1] = i_valid.
  - ctrl[k] and data[k] load from stage k-1 (or i_ctrl, i_data) only when the source is valid; otherwise the payload holds.
- Stalled stages (rdy[k] = 0) hold everything.
- Enable low (i_enable = 0, i_flush = 0): no state change and no transfer on either side; o_count holds.
- Flush (i_flush = 1):
  - Next edge clears every v[k] to 0, regardless of i_enable, i_valid or i_ready.
  - The upstream beat offered that cycle is consumed and discarded (o_ready = 1).
  - Payload registers hold their values.
- Simultaneous events: flush dominates enable and both handshakes. Reset dominates everything.
- o_ctrl = (ZERO_CTRL_ON_BUBBLE & !o_valid) ? 0 : ctrl[DEPTH-1].
- o_data = data[DEPTH-1], always raw.
- o_count = popcount(v), registered. Range 0..DEPTH, no wrap.
- Latency: DEPTH cycles from input acceptance to o_valid when unstalled. Throughput: 1 beat per cycle.
- DEPTH = 1 degenerates to a single valid/ready register; it must still pass every test below.

Test Plan (DEPTH = 2, CTRL_WIDTH = 8, DATA_WIDTH = 64):
- Reset and release:
  - Pulse i_reset low mid-cycle -> outputs and o_count go to 0 without waiting for a clock.
  - After release, o_ready = 1 and o_valid = 0.
- Streaming:
  - Drive beats D0 = 0x11, D1 = 0x22, D2 = 0x33 (ctrl = 0x1F) on consecutive cycles with i_ready = 1.
  - D0 appears on o_data exactly 2 cycles after acceptance, then one beat per cycle; o_count holds at 2 in steady state.
- Back-pressure:
  - Hold i_ready = 0 with the pipe full -> o_ready = 0, o_data stays D0 and o_count = 2.
  - Raise i_ready -> D0, D1, D2 drain in order with no gaps or duplicates.
- Flush with pipe full and i_valid = 1 (D3):
  - Next cycle o_valid = 0, o_ctrl = 0x00 and o_count = 0.
  - D3 never appears at the output.
- Enable low:
  - Hold i_enable = 0 for 3 cycles mid-stream -> o_ready = 0, o_valid = 0, no state change.
  - Re-enable -> the stream resumes with the same next beat.
- Bubble masking:
  - Leave a 1-cycle gap in i_valid with ctrl = 0xFF preceding it -> o_ctrl = 0x00 in the bubble slot while o_data holds its last value.
